exec_trace_buffer: RTL

- Synthesizable commit-trace capture for the MIPS core. It replaces the simulation-only $monitor style of observing instructions and register writes.
- Records per-instruction commit events (PC, instruction word, register write) into a parametrised circular buffer.
- Supports arm/trigger/stop control, selectable stop-when-full or wrap (overwrite-oldest) mode, and a valid/ready readout stream.
- Sits beside `processador`, fed from its fetch and writeback signals.

---
 rtl/trace_pkg.sv | 36 +++
 rtl/trace_ram.sv | 26 ++
 rtl/exec_trace_buffer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the execution trace buffer.
// Holds FSM encodings and the packing layout of one trace entry.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2
    } state_t;

    // Entry layout, LSB first: rd, we, data, instr, pc.
    function automatic int entry_w(int dw, int rw);
        return 3 * dw + rw + 1;
    endfunction

    function automatic int off_rd(int dw, int rw);
        return 0;
    endfunction

    function automatic int off_we(int dw, int rw);
        return rw;
    endfunction

    function automatic int off_data(int dw, int rw);
        return rw + 1;
    endfunction

    function automatic int off_instr(int dw, int rw);
        return rw + 1 + dw;
    endfunction

    function automatic int off_pc(int dw, int rw);
        return rw + 1 + 2 * dw;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read.
// Ports: clk, i_we/i_waddr/i_wdata write port, i_raddr/o_rdata read port.
module trace_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 102,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/exec_trace_buffer.sv
// Commit-trace capture with arm/trigger/stop control and stream readout.
// Ports: commit_* event in, arm/trig/stop/wrap/clear control, out_* stream, status.
module exec_trace_buffer
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16,
    parameter int AW     = $clog2(DEPTH),
    parameter int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit_valid,
    input  logic [DATA_W-1:0] commit_pc,
    input  logic [DATA_W-1:0] commit_instr,
    input  logic              commit_we,
    input  logic [REG_W-1:0]  commit_rd,
    input  logic [DATA_W-1:0] commit_data,
    input  logic              arm,
    input  logic              trig_en,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic              stop,
    input  logic              wrap_mode,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_we,
    output logic [REG_W-1:0]  out_rd,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [1:0]        state
);

    localparam int EW = entry_w(DATA_W, REG_W);

    state_t             r_state;
    state_t             w_next;
    logic [AW-1:0]      r_wptr;
    logic [AW-1:0]      r_rptr;
    logic [CW-1:0]      r_count;
    logic [DROP_W-1:0]  r_drop;

    logic               w_match;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_write;
    logic               w_overwrite;
    logic               w_drop;
    logic               w_inc;
    logic [EW-1:0]      w_wdata;
    logic [EW-1:0]      w_rdata;

    assign w_match = commit_valid && (commit_pc == trig_pc);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Stop wins over a same-cycle commit; clear discards everything.
    assign w_push = !clear && !stop &&
                    (((r_state == ST_CAPTURE) && commit_valid) ||
                     ((r_state == ST_WAIT_TRIG) && w_match));
    assign w_pop  = !clear && !w_empty && out_ready;

    // When full, a push lands only if a pop frees a slot or we overwrite.
    assign w_write     = w_push && (!w_full || w_pop || wrap_mode);
    assign w_overwrite = w_push && w_full && !w_pop && wrap_mode;
    assign w_drop      = w_push && w_full && !w_pop;
    assign w_inc       = w_write && !w_overwrite;

    assign w_wdata = {commit_pc, commit_instr, commit_data,
                      commit_we, commit_rd};

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_write && reset),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!clear) begin
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        w_next = trig_en ? ST_WAIT_TRIG : ST_CAPTURE;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (stop) begin
                        w_next = ST_IDLE;
                    end else if (w_match) begin
                        w_next = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (stop) begin
                        w_next = ST_IDLE;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else begin
            if (w_write) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop || w_overwrite) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_inc && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_inc && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + DROP_W'(1);
            end
        end
    end

    assign out_pc    = w_rdata[off_pc(DATA_W, REG_W) +: DATA_W];
    assign out_instr = w_rdata[off_instr(DATA_W, REG_W) +: DATA_W];
    assign out_data  = w_rdata[off_data(DATA_W, REG_W) +: DATA_W];
    assign out_we    = w_rdata[off_we(DATA_W, REG_W)];
    assign out_rd    = w_rdata[off_rd(DATA_W, REG_W) +: REG_W];

    assign out_valid = !w_empty;
    assign empty     = w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign drop_cnt  = r_drop;
    assign state     = r_state;

endmodule
